// File: rtl/simple_spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by system_clk; pins pass through 2-FF sync + edge-detect stage.
// Latency: pin edges act 2-3 cycles late; value_valid/value_mosi appear 1 cycle after the last synced rise.
module simple_spi_slave #(
   parameter int WIDTH = 8
) (
   input  logic             system_clk,
   input  logic             system_nrst,
   input  logic             pin_ncs,
   input  logic             pin_clk,
   input  logic             pin_mosi,
   output logic             pin_miso,
   output logic             pin_miso_en,
   input  logic [WIDTH-1:0] value_miso,
   output logic [WIDTH-1:0] value_mosi,
   output logic             cs_active,
   output logic             cs_start,
   output logic             cs_stop,
   output logic             value_valid
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   // [0],[1] form the synchronizer; [2] is the previous synced value for edge detection
   logic [2:0]       ncs_sync_q;
   logic [2:0]       clk_sync_q;
   logic [2:0]       mosi_sync_q;

   logic             cs_active_q,   cs_active_d;
   logic             cs_start_q,    cs_start_d;
   logic             cs_stop_q,     cs_stop_d;
   logic             value_valid_q, value_valid_d;
   logic [WIDTH-1:0] value_mosi_q,  value_mosi_d;
   logic [WIDTH-1:0] rx_q,          rx_d;
   logic [WIDTH-1:0] tx_q,          tx_d;
   logic [CW-1:0]    cnt_q,         cnt_d;

   logic ncs_fall, ncs_rise, sclk_rise, sclk_fall, mosi_bit;

   assign ncs_fall  =  ncs_sync_q[2] & ~ncs_sync_q[1];
   assign ncs_rise  = ~ncs_sync_q[2] &  ncs_sync_q[1];
   assign sclk_rise = ~clk_sync_q[2] &  clk_sync_q[1];
   assign sclk_fall =  clk_sync_q[2] & ~clk_sync_q[1];
   assign mosi_bit  =  mosi_sync_q[1];

   always_comb begin
      cs_active_d   = cs_active_q;
      cs_start_d    = 1'b0;
      cs_stop_d     = 1'b0;
      value_valid_d = 1'b0;
      value_mosi_d  = value_mosi_q;
      rx_d          = rx_q;
      tx_d          = tx_q;
      cnt_d         = cnt_q;

      // cs_stop wins over any clock edge landing in the same cycle
      if (ncs_rise) begin
         cs_active_d = 1'b0;
         cs_stop_d   = 1'b1;
      end else if (ncs_fall) begin
         cs_active_d = 1'b1;
         cs_start_d  = 1'b1;
         cnt_d       = '0;
         tx_d        = value_miso;
      end else if (cs_active_q) begin
         if (sclk_rise) begin
            rx_d = {rx_q[WIDTH-2:0], mosi_bit};
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d         = '0;
               value_mosi_d  = {rx_q[WIDTH-2:0], mosi_bit};
               value_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else if (sclk_fall) begin
            // counter at 0 here means a word just finished: reload for back-to-back words
            if (cnt_q == '0) tx_d = value_miso;
            else             tx_d = {tx_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge system_clk or negedge system_nrst) begin
      if (!system_nrst) begin
         ncs_sync_q    <= 3'b111;
         clk_sync_q    <= 3'b000;
         mosi_sync_q   <= 3'b000;
         cs_active_q   <= 1'b0;
         cs_start_q    <= 1'b0;
         cs_stop_q     <= 1'b0;
         value_valid_q <= 1'b0;
         value_mosi_q  <= '0;
         rx_q          <= '0;
         tx_q          <= '0;
         cnt_q         <= '0;
      end else begin
         ncs_sync_q    <= {ncs_sync_q[1:0], pin_ncs};
         clk_sync_q    <= {clk_sync_q[1:0], pin_clk};
         mosi_sync_q   <= {mosi_sync_q[1:0], pin_mosi};
         cs_active_q   <= cs_active_d;
         cs_start_q    <= cs_start_d;
         cs_stop_q     <= cs_stop_d;
         value_valid_q <= value_valid_d;
         value_mosi_q  <= value_mosi_d;
         rx_q          <= rx_d;
         tx_q          <= tx_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cs_active   = cs_active_q;
   assign cs_start    = cs_start_q;
   assign cs_stop     = cs_stop_q;
   assign value_valid = value_valid_q;
   assign value_mosi  = value_mosi_q;
   assign pin_miso_en = cs_active_q;
   assign pin_miso    = cs_active_q & tx_q[WIDTH-1];

endmodule

// File: tb/tb_simple_spi_slave.sv
// Directed bench for simple_spi_slave (WIDTH=4): table of word pairs plus abort, back-to-back and reset sequences.
module tb_simple_spi_slave;

   localparam int W = 4;

   logic         system_clk = 1'b0;
   logic         system_nrst;
   logic         pin_ncs, pin_clk, pin_mosi;
   logic         pin_miso, pin_miso_en;
   logic [W-1:0] value_miso, value_mosi;
   logic         cs_active, cs_start, cs_stop, value_valid;

   simple_spi_slave #(.WIDTH(W)) dut (
      .system_clk (system_clk),
      .system_nrst(system_nrst),
      .pin_ncs    (pin_ncs),
      .pin_clk    (pin_clk),
      .pin_mosi   (pin_mosi),
      .pin_miso   (pin_miso),
      .pin_miso_en(pin_miso_en),
      .value_miso (value_miso),
      .value_mosi (value_mosi),
      .cs_active  (cs_active),
      .cs_start   (cs_start),
      .cs_stop    (cs_stop),
      .value_valid(value_valid)
   );

   always #1 system_clk = ~system_clk;

   int total = 0;
   int bad   = 0;

   // pulse counts are high-cycle counts, so a 2-cycle-wide pulse shows up as 2
   int           n_valid = 0, n_start = 0, n_stop = 0, n_viol = 0;
   logic [W-1:0] rx_log [$];

   always @(negedge system_clk) begin
      if (value_valid) begin
         n_valid++;
         rx_log.push_back(value_mosi);
      end
      if (cs_start) n_start++;
      if (cs_stop)  n_stop++;
      if ((pin_miso_en !== cs_active) || (!cs_active && pin_miso !== 1'b0)) n_viol++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Master shifts nbits of tx (MSB first); value_miso changes to next_miso during the last high phase.
   task automatic shift_bits(input logic [W-1:0] tx, input int nbits,
                             input logic [W-1:0] next_miso, output logic [W-1:0] cap);
      cap = '0;
      for (int i = 0; i < nbits; i++) begin
         pin_mosi = tx[W-1-i];
         #100 pin_clk = 1'b1;
         cap[W-1-i] = pin_miso;
         #50;
         if (i == nbits - 1) value_miso = next_miso;
         #50 pin_clk = 1'b0;
      end
   endtask

   task automatic transfer(input logic [W-1:0] miso_w, input logic [W-1:0] mosi_w,
                           output logic [W-1:0] cap);
      value_miso = miso_w;
      #20 pin_ncs = 1'b0;
      shift_bits(mosi_w, W, miso_w, cap);
      #100 pin_ncs = 1'b1;
      #100;
   endtask

   typedef struct {
      logic [W-1:0] miso;
      logic [W-1:0] mosi;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int v0, s0, p0, x0;
      logic [W-1:0] cap, cap2, last;

      vecs[0]  = '{4'b1010, 4'b0110};
      vecs[1]  = '{4'b0000, 4'b1111};
      vecs[2]  = '{4'b0101, 4'b1010};
      vecs[3]  = '{4'b1111, 4'b0000};
      vecs[4]  = '{4'b0001, 4'b1000};
      vecs[5]  = '{4'b0010, 4'b0100};
      vecs[6]  = '{4'b0100, 4'b0010};
      vecs[7]  = '{4'b1000, 4'b0001};
      vecs[8]  = '{4'b1110, 4'b0111};
      vecs[9]  = '{4'b1101, 4'b1011};
      vecs[10] = '{4'b1011, 4'b1101};
      vecs[11] = '{4'b0111, 4'b1110};
      vecs[12] = '{4'b1110, 4'b1110};

      system_nrst = 1'b0;
      pin_ncs     = 1'b1;
      pin_clk     = 1'b0;
      pin_mosi    = 1'b0;
      value_miso  = 4'b1010;
      #11;
      check("reset_outputs",
            {27'd0, pin_miso, pin_miso_en, cs_active, cs_start, cs_stop},
            32'd0);
      check("reset_value", {27'd0, value_valid, value_mosi}, 32'd0);
      #10 system_nrst = 1'b1;
      #20;
      check("idle_outputs", {28'd0, pin_miso, pin_miso_en, cs_active, value_valid}, 32'd0);

      for (int k = 0; k < 13; k++) begin
         v0 = n_valid; s0 = n_start; p0 = n_stop; x0 = n_viol;
         transfer(vecs[k].miso, vecs[k].mosi, cap);
         check($sformatf("v%0d_valid_cnt", k), n_valid - v0, 1);
         check($sformatf("v%0d_mosi", k), (rx_log.size() > 0) ? rx_log[$] : 4'hx, vecs[k].mosi);
         check($sformatf("v%0d_value_hold", k), value_mosi, vecs[k].mosi);
         check($sformatf("v%0d_miso_cap", k), cap, vecs[k].miso);
         check($sformatf("v%0d_start_cnt", k), n_start - s0, 1);
         check($sformatf("v%0d_stop_cnt", k), n_stop - p0, 1);
         check($sformatf("v%0d_oe_viol", k), n_viol - x0, 0);
      end

      // abort after 2 of 4 bits: previous word must survive
      last = value_mosi;
      v0 = n_valid; s0 = n_start; p0 = n_stop;
      value_miso = 4'b1100;
      #20 pin_ncs = 1'b0;
      shift_bits(4'b1001, 2, 4'b1100, cap);
      #100 pin_ncs = 1'b1;
      #100;
      check("abort_no_valid", n_valid - v0, 0);
      check("abort_value_kept", value_mosi, last);
      check("abort_start_stop", {n_start - s0, n_stop - p0}, {32'd1, 32'd1});
      check("abort_cap_msbs", cap[3:2], 2'b11);
      check("abort_idle", {cs_active, pin_miso_en, pin_miso}, 3'b000);

      transfer(4'b0110, 4'b1001, cap);
      check("post_abort_mosi", value_mosi, 4'b1001);
      check("post_abort_miso", cap, 4'b0110);

      // two words in one CS; value_miso swapped before the word-boundary fall
      v0 = n_valid; s0 = n_start; p0 = n_stop;
      value_miso = 4'b1001;
      #20 pin_ncs = 1'b0;
      shift_bits(4'b0011, W, 4'b0110, cap);
      shift_bits(4'b1100, W, 4'b0110, cap2);
      #100 pin_ncs = 1'b1;
      #100;
      check("b2b_valid_cnt", n_valid - v0, 2);
      check("b2b_word0", rx_log[rx_log.size()-2], 4'b0011);
      check("b2b_word1", rx_log[rx_log.size()-1], 4'b1100);
      check("b2b_miso0", cap, 4'b1001);
      check("b2b_miso1", cap2, 4'b0110);
      check("b2b_start_stop", {n_start - s0, n_stop - p0}, {32'd1, 32'd1});

      // reset in the middle of a word
      value_miso = 4'b1111;
      #20 pin_ncs = 1'b0;
      shift_bits(4'b0101, 2, 4'b1111, cap);
      #37 system_nrst = 1'b0;
      #1;
      check("midreset_ctl",
            {27'd0, pin_miso, pin_miso_en, cs_active, cs_start, cs_stop}, 32'd0);
      check("midreset_value", {27'd0, value_valid, value_mosi}, 32'd0);
      pin_ncs = 1'b1;
      #20 system_nrst = 1'b1;
      #20;
      v0 = n_valid;
      transfer(4'b0011, 4'b1010, cap);
      check("post_reset_valid_cnt", n_valid - v0, 1);
      check("post_reset_mosi", value_mosi, 4'b1010);
      check("post_reset_miso", cap, 4'b0011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/simple_spi_slave.md
Name: simple_spi_slave

Overview:
SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, with a fixed word width, oversampled by a fast system clock. It synchronizes the asynchronous SPI pins into the system_clk domain and shifts words in on MOSI and out on MISO. It presents received words and chip-select events to on-chip logic as single-cycle strobes. It sits between the device pins and a register/command block.

Parameters:
WIDTH, 8, bits per SPI word (≥2).

Ports:
system_clk  input  1  system clock; all logic on its rising edge.
system_nrst  input  1  asynchronous active-low reset.
pin_ncs  input  1  chip select from pin, active low, asynchronous.
pin_clk  input  1  SPI clock from pin, idle low, asynchronous.
pin_mosi  input  1  serial data from master.
pin_miso  output  1  serial data to master.
pin_miso_en  output  1  output-enable for the MISO pad driver.
value_miso  input  WIDTH  word to transmit; sampled at load points.
value_mosi  output  WIDTH  last fully received word.
cs_active  output  1  high while synchronized chip select is asserted.
cs_start  output  1  one-cycle pulse on synchronized ncs falling edge.
cs_stop  output  1  one-cycle pulse on synchronized ncs rising edge.
value_valid  output  1  one-cycle pulse when value_mosi holds a new complete word.

Behaviour:
- Reset is asynchronous and active-low. The reset state is:
  - all outputs 0;
  - ncs synchronizer stages 1;
  - clk synchronizer stages 0;
  - bit counter 0;
  - both shift registers 0.
- Synchronization:
  - pin_ncs, pin_clk and pin_mosi each pass through a 2-FF synchronizer.
  - A third register per signal provides edge detection.
  - Edge events are therefore seen 2–3 system_clk cycles after the pin change.
- Timing requirement on the master:
  - pin_clk high and low phases each ≥4 system_clk cycles.
  - ncs falling edge to first pin_clk rise ≥4 cycles.
  - Last pin_clk fall to ncs rise ≥0 (ncs may rise while clk is already low).
- cs_start (synchronized ncs falling edge):
  - cs_start pulses; cs_active goes 1.
  - Bit counter cleared to 0.
  - TX shift register loaded with value_miso in the same cycle.
- cs_stop (synchronized ncs rising edge):
  - cs_stop pulses; cs_active goes 0.
  - A partial word is discarded: no value_valid, value_mosi unchanged.
- pin_miso_en equals cs_active.
- pin_miso:
  - equals TX shift register MSB while cs_active;
  - 0 otherwise.
- Synchronized pin_clk rising edge while cs_active:
  - RX shift register shifts left, inserting the synchronized mosi bit.
  - Bit counter increments.
  - When the counter reaches WIDTH: value_mosi is updated with the complete word (including the bit just sampled) on the next cycle, value_valid pulses for exactly 1 cycle with it, and the counter wraps to 0.
- Synchronized pin_clk falling edge while cs_active:
  - Counter ≠ 0: TX shifts left by one, filling with 0.
  - Counter = 0 (a word just completed): TX reloads from value_miso, giving back-to-back words within one CS.
- MISO settling: the master samples MISO at the rising pin_clk edge, so the MSB must be on pin_miso before the first rise (guaranteed by the load at cs_start). Each subsequent bit appears after a falling edge.
- Clock edges while ncs is inactive are ignored.
- Simultaneous events: a cs_stop edge in the same cycle as a clk edge gives cs_stop priority; that clk edge is ignored.
- value_mosi holds its value until the next completed word or reset.
- Reset mid-transfer aborts immediately to the reset state. After reset, wait for the next ncs falling edge.

Test Plan:
- WIDTH=4; value_miso=4'b1010, master sends 4'b0110 (100 ns half-periods, system_clk period 2 ns) -> one value_valid pulse with value_mosi=0110; master captures 1010 on rising edges.
- Patterns (1010/0110), (0000/1111), (0101/1010), (1111/0000), walking-one 0001/1000, 0010/0100, 0100/0010, 1000/0001, walking-zero 1110/0111, 1101/1011, 1011/1101, 0111/1110, (1110/1110) -> exact match both directions every word.
- Each transfer -> cs_start then cs_stop exactly once, each 1 cycle wide. pin_miso_en high only between them; pin_miso=0 outside CS.
- Abort: ncs high after 2 of 4 bits -> no value_valid, value_mosi keeps previous word. The next full transfer is correct.
- Two words in one CS (send 0011 then 1100, value_miso changed between words) -> two value_valid pulses, correct MOSI values; the second MISO word is the value_miso sampled at the word boundary.
- Assert system_nrst mid-word -> all outputs 0 immediately. A subsequent full transfer succeeds.
